// File: rtl/rn_ds_skid.sv
// Rename-to-dispatch skid buffer: a MAIN register drives dispatch, a SKID
// register absorbs one bundle so in_ready can be registered.
module rn_ds_skid #(
    parameter int LANES   = 4,
    parameter int ALUOP_W = 9,
    parameter int AREG_W  = 5,
    parameter int PREG_W  = 6,
    parameter int IMM_W   = 32,
    parameter int PC_W    = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [PC_W-1:0]       in_pc,
    input  logic [LANES-1:0]      in_lane_valid,
    input  logic [LANES*(ALUOP_W+3*AREG_W+3*PREG_W+IMM_W)-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [PC_W-1:0]       out_pc,
    output logic [LANES-1:0]      out_lane_valid,
    output logic [LANES*(ALUOP_W+3*AREG_W+3*PREG_W+IMM_W)-1:0] out_data,
    output logic [1:0]            occ
);
    localparam int LW = ALUOP_W + 3*AREG_W + 3*PREG_W + IMM_W;
    localparam int DW = LANES * LW;

    logic             main_v_q, main_v_d;
    logic [PC_W-1:0]  main_pc_q, main_pc_d;
    logic [LANES-1:0] main_lv_q, main_lv_d;
    logic [DW-1:0]    main_data_q, main_data_d;
    logic             skid_v_q, skid_v_d;
    logic [PC_W-1:0]  skid_pc_q, skid_pc_d;
    logic [LANES-1:0] skid_lv_q, skid_lv_d;
    logic [DW-1:0]    skid_data_q, skid_data_d;
    logic             in_ready_q, in_ready_d;
    logic [1:0]       occ_q, occ_d;

    logic in_fire, storable, out_fire;

    always_comb begin
        in_fire     = in_valid && in_ready_q;
        storable    = in_fire && (in_lane_valid != '0);
        out_fire    = main_v_q && out_ready;
        main_v_d    = main_v_q;
        main_pc_d   = main_pc_q;
        main_lv_d   = main_lv_q;
        main_data_d = main_data_q;
        skid_v_d    = skid_v_q;
        skid_pc_d   = skid_pc_q;
        skid_lv_d   = skid_lv_q;
        skid_data_d = skid_data_q;
        if (flush) begin
            main_v_d    = 1'b0;
            main_pc_d   = '0;
            main_lv_d   = '0;
            main_data_d = '0;
            skid_v_d    = 1'b0;
            skid_pc_d   = '0;
            skid_lv_d   = '0;
            skid_data_d = '0;
        end else if (!main_v_q) begin
            if (storable) begin
                main_v_d    = 1'b1;
                main_pc_d   = in_pc;
                main_lv_d   = in_lane_valid;
                main_data_d = in_data;
            end
        end else if (out_fire) begin
            if (skid_v_q) begin
                main_pc_d   = skid_pc_q;
                main_lv_d   = skid_lv_q;
                main_data_d = skid_data_q;
                skid_v_d    = 1'b0;
            end else if (storable) begin
                main_pc_d   = in_pc;
                main_lv_d   = in_lane_valid;
                main_data_d = in_data;
            end else begin
                main_v_d    = 1'b0;
            end
        end else if (storable) begin
            // in_ready guarantees SKID is empty here
            skid_v_d    = 1'b1;
            skid_pc_d   = in_pc;
            skid_lv_d   = in_lane_valid;
            skid_data_d = in_data;
        end
        in_ready_d = !skid_v_d;
        occ_d      = {1'b0, main_v_d} + {1'b0, skid_v_d};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_v_q    <= 1'b0;
            main_pc_q   <= '0;
            main_lv_q   <= '0;
            main_data_q <= '0;
            skid_v_q    <= 1'b0;
            skid_pc_q   <= '0;
            skid_lv_q   <= '0;
            skid_data_q <= '0;
            in_ready_q  <= 1'b1;
            occ_q       <= 2'd0;
        end else begin
            main_v_q    <= main_v_d;
            main_pc_q   <= main_pc_d;
            main_lv_q   <= main_lv_d;
            main_data_q <= main_data_d;
            skid_v_q    <= skid_v_d;
            skid_pc_q   <= skid_pc_d;
            skid_lv_q   <= skid_lv_d;
            skid_data_q <= skid_data_d;
            in_ready_q  <= in_ready_d;
            occ_q       <= occ_d;
        end
    end

    assign in_ready       = in_ready_q;
    assign occ            = occ_q;
    assign out_valid      = main_v_q;
    assign out_pc         = main_v_q ? main_pc_q : '0;
    assign out_lane_valid = main_v_q ? main_lv_q : '0;
    assign out_data       = main_v_q ? main_data_q : '0;

endmodule

// File: tb/tb_rn_ds_skid.sv
// Scoreboard bench for rn_ds_skid: ordered queue of accepted bundles,
// plus a reduced-width instance checking lane field packing.
module tb_rn_ds_skid;
    localparam int LW = 9 + 15 + 18 + 32;
    localparam int DW = 4 * LW;
    localparam int LW2 = 9 + 15 + 18 + 16;
    localparam int DW2 = 2 * LW2;

    typedef struct {
        logic [31:0]   pc;
        logic [3:0]    lv;
        logic [DW-1:0] data;
    } bundle_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b1, flush = 1'b0;
    logic          in_valid = 1'b0, out_ready = 1'b0;
    logic [31:0]   in_pc = '0;
    logic [3:0]    in_lane_valid = '0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready, out_valid;
    logic [31:0]   out_pc;
    logic [3:0]    out_lane_valid;
    logic [DW-1:0] out_data;
    logic [1:0]    occ;

    rn_ds_skid dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_lane_valid(in_lane_valid), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_lane_valid(out_lane_valid),
        .out_data(out_data), .occ(occ)
    );

    logic           p_rst = 1'b1, p_flush = 1'b0;
    logic           p_in_valid = 1'b0, p_out_ready = 1'b1;
    logic [31:0]    p_in_pc = '0;
    logic [1:0]     p_in_lv = '0;
    logic [DW2-1:0] p_in_data = '0;
    logic           p_in_ready, p_out_valid;
    logic [31:0]    p_out_pc;
    logic [1:0]     p_out_lv;
    logic [DW2-1:0] p_out_data;
    logic [1:0]     p_occ;

    rn_ds_skid #(.LANES(2), .IMM_W(16)) dut2 (
        .clk(clk), .rst(p_rst), .flush(p_flush),
        .in_valid(p_in_valid), .in_ready(p_in_ready),
        .in_pc(p_in_pc), .in_lane_valid(p_in_lv), .in_data(p_in_data),
        .out_valid(p_out_valid), .out_ready(p_out_ready),
        .out_pc(p_out_pc), .out_lane_valid(p_out_lv),
        .out_data(p_out_data), .occ(p_occ)
    );

    int n_chk = 0;
    int n_fail = 0;
    bit started = 1'b0;
    bundle_t sb[$];

    task automatic chk(input string nm, input logic [511:0] act,
                       input logic [511:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: stored count in the model fixes valid/occ/ready; a
    // presented bundle consumed by dispatch must be the oldest accepted.
    always @(negedge clk) begin
        if (started) begin
            chk("out_valid", 512'(out_valid), 512'(sb.size() > 0));
            chk("occ", 512'(occ), 512'(sb.size()));
            chk("in_ready", 512'(in_ready), 512'(sb.size() < 2));
            if (sb.size() == 0) begin
                chk("idle_out", {out_pc, out_lane_valid, out_data}, '0);
            end else if (out_ready) begin
                bundle_t e;
                e = sb.pop_front();
                chk("out_pc", 512'(out_pc), 512'(e.pc));
                chk("out_lane_valid", 512'(out_lane_valid), 512'(e.lv));
                chk("out_data", 512'(out_data), 512'(e.data));
            end
        end
    end

    function automatic logic [DW-1:0] rnd_data();
        logic [DW-1:0] d;
        for (int i = 0; i < DW; i++) d[i] = 1'($urandom_range(1, 0));
        return d;
    endfunction

    task automatic drive(input bit v, input logic [31:0] pc,
                         input logic [3:0] lv, input bit ordy,
                         input bit fl, input bit r);
        bit acc;
        logic [DW-1:0] d;
        @(posedge clk);
        #1;
        d = rnd_data();
        in_valid = v; in_pc = pc; in_lane_valid = lv; in_data = d;
        out_ready = ordy; flush = fl; rst = r;
        acc = v && (sb.size() < 2);
        @(negedge clk);
        #1;
        if (r || fl) sb.delete();
        else if (acc && lv != 4'd0) sb.push_back('{pc, lv, d});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 1, 0, 0);
    endtask

    initial begin
        logic [LW2-1:0] rec1, got1;
        drive(0, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 1);
        started = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        // streaming
        drive(1, 32'h100, 4'hF, 1, 0, 0);
        drive(1, 32'h110, 4'hF, 1, 0, 0);
        drive(1, 32'h120, 4'hF, 1, 0, 0);
        idle(3);
        // backpressure, 0x220 held until accepted
        drive(1, 32'h200, 4'hF, 0, 0, 0);
        drive(1, 32'h210, 4'hF, 0, 0, 0);
        drive(1, 32'h220, 4'hF, 0, 0, 0);
        drive(1, 32'h220, 4'hF, 1, 0, 0);
        drive(1, 32'h220, 4'hF, 1, 0, 0);
        idle(3);
        // empty mask consumed, not stored
        drive(1, 32'h300, 4'h0, 1, 0, 0);
        drive(1, 32'h310, 4'h3, 1, 0, 0);
        idle(3);
        // flush with both registers full
        drive(1, 32'h3A0, 4'hF, 0, 0, 0);
        drive(1, 32'h3B0, 4'hF, 0, 0, 0);
        drive(1, 32'h400, 4'hF, 0, 1, 0);
        idle(3);
        // reset priority
        drive(1, 32'h500, 4'hF, 0, 0, 0);
        drive(1, 32'h510, 4'h5, 0, 0, 0);
        drive(1, 32'h520, 4'hF, 1, 0, 1);
        idle(3);
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(3, 0) != 0),
                  32'($urandom()),
                  ($urandom_range(5, 0) == 0) ? 4'd0 : 4'($urandom()),
                  ($urandom_range(2, 0) != 0),
                  ($urandom_range(59, 0) == 0),
                  ($urandom_range(149, 0) == 0));
        end
        idle(4);
        // reduced-width instance: lane 1 field packing
        rec1 = {9'h1A5, 5'd3, 5'd17, 5'd30, 6'd9, 6'd33, 6'd62, 16'hBEEF};
        @(posedge clk); #1;
        p_rst = 1'b0;
        @(posedge clk); #1;
        p_in_valid = 1'b1; p_in_pc = 32'h600; p_in_lv = 2'b10;
        p_in_data = {rec1, 58'h2_1234_5678_9ABC};
        @(posedge clk); #1;
        p_in_valid = 1'b0; p_out_ready = 1'b0;
        @(negedge clk);
        got1 = p_out_data[LW2 +: LW2];
        chk("p_out_valid", 512'(p_out_valid), 512'(1));
        chk("p_out_pc", 512'(p_out_pc), 512'h600);
        chk("p_out_lv", 512'(p_out_lv), 512'(2'b10));
        chk("p_aluop", 512'(got1[57:49]), 512'h1A5);
        chk("p_src1", 512'(got1[48:44]), 512'd3);
        chk("p_src2", 512'(got1[43:39]), 512'd17);
        chk("p_rdst", 512'(got1[38:34]), 512'd30);
        chk("p_rsrc1", 512'(got1[33:28]), 512'd9);
        chk("p_rsrc2", 512'(got1[27:22]), 512'd33);
        chk("p_phydst", 512'(got1[21:16]), 512'd62);
        chk("p_imm", 512'(got1[15:0]), 512'hBEEF);
        chk("p_lane0", 512'(p_out_data[LW2-1:0]), 512'h2_1234_5678_9ABC);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
